// File: rtl/md_sched.sv
// Multiply/divide scheduler: models fixed MD latency with a busy counter,
// owns HI/LO and raises the D-stage stall for MD-using instructions.
module md_sched #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_valid,
  input  logic [2:0]  md_op,
  input  logic        cancel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_md_use,
  output logic        start,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          busy_q, busy_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic          pend_wr_q, pend_wr_d;

  logic          accept_c, is_mult_c, is_div_c;
  logic [63:0]   op_a64_c, op_b64_c, prod_c;
  logic          neg_a_c, neg_b_c;
  logic [31:0]   mag_a_c, mag_b_c, den_c, quo_c, rem_c, q_res_c, r_res_c;

  // Accept/start decode and the D-stage stall request
  always_comb begin
    accept_c  = md_valid & ~cancel & ~busy_q;
    is_mult_c = (md_op == OP_MULT) | (md_op == OP_MULTU);
    is_div_c  = (md_op == OP_DIV)  | (md_op == OP_DIVU);
  end

  assign start = accept_c & (is_mult_c | is_div_c);
  assign stall = d_md_use & (start | busy_q);
  assign busy  = busy_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

  // Result computed at start; low 64 bits of a 64x64 product of extended operands
  always_comb begin
    op_a64_c = (md_op == OP_MULT) ? {{32{a[31]}}, a} : {32'd0, a};
    op_b64_c = (md_op == OP_MULT) ? {{32{b[31]}}, b} : {32'd0, b};
    prod_c   = op_a64_c * op_b64_c;

    // Signed divide via magnitudes; 0x80000000/-1 falls out as 0x80000000 r 0
    neg_a_c = (md_op == OP_DIV) & a[31];
    neg_b_c = (md_op == OP_DIV) & b[31];
    mag_a_c = neg_a_c ? (32'd0 - a) : a;
    mag_b_c = neg_b_c ? (32'd0 - b) : b;
    den_c   = (b == 32'd0) ? 32'd1 : mag_b_c;
    quo_c   = mag_a_c / den_c;
    rem_c   = mag_a_c % den_c;
    q_res_c = (neg_a_c ^ neg_b_c) ? (32'd0 - quo_c) : quo_c;
    r_res_c = neg_a_c ? (32'd0 - rem_c) : rem_c;
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    busy_d    = busy_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          busy_d  = 1'b1;
          if (is_mult_c) begin
            count_d   = CW'(MULT_CYCLES);
            pend_hi_d = prod_c[63:32];
            pend_lo_d = prod_c[31:0];
            pend_wr_d = 1'b1;
          end else begin
            count_d   = CW'(DIV_CYCLES);
            pend_hi_d = r_res_c;
            pend_lo_d = q_res_c;
            pend_wr_d = (b != 32'd0);
          end
        end else if (accept_c && md_op == OP_MTHI) begin
          hi_d = a;
        end else if (accept_c && md_op == OP_MTLO) begin
          lo_d = a;
        end
      end
      S_RUN: begin
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          count_d = '0;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

endmodule
